id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the 5-stage 32-bit RISC pipeline. It holds the 32×32 register file with a single writeback port and performs operand reads with write-through bypass. It detects load-use hazards against the instruction currently in EXE and inserts bubbles. Its `out_*` signals feed the ID/EXE pipeline register directly.

## Interface
- `DW`, 32, data width
- `IW`, 32, instruction width
- `NREG`, 32, register count (5-bit index)
- `CW`, 16, stall-counter width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_inst`  in  `IW`  instruction from IF/ID register
- `ex_inst`  in  `IW`  instruction currently in EXE (ID/EXE output)
- `flush`  in  1  branch taken; kill the instruction in ID
- `wb_en`  in  1  writeback enable
- `wb_rd`  in  5  writeback register index
- `wb_data`  in  `DW`  writeback value
- `out_r1`  out  `DW`  rs1 operand
- `out_r2`  out  `DW`  rs2 operand
- `out_inst`  out  `IW`  instruction forwarded to EXE (NOP on bubble)
- `stall`  out  1  hold PC and IF/ID this cycle
- `stall_cnt`  out  `CW`  saturating count of bubble cycles inserted

## Operation
- Field layout:
  - opcode `[31:26]`, rd `[25:21]`, rs1 `[20:16]`, rs2 `[15:11]`.
  - `OP_LOAD` = 6'h23; `NOP` = 32'h0000_0000.
- Register file:
  - r0 reads 0 always; writes to r0 are ignored.
  - Write occurs on the `clk` edge when `wb_en`=1 and `wb_rd`≠0.
- Read bypass:
  - If `wb_en`=1, `wb_rd`≠0 and `wb_rd` equals rs1, `out_r1`=`wb_data` in the same cycle.
  - The same rule applies to rs2 → `out_r2`.
- Load-use hazard: `hz` = (`ex_inst[31:26]`==`OP_LOAD`) && (ex rd ≠ 0) && (ex rd == rs1 || ex rd == rs2).
  - rs2 is compared for every opcode. This is conservative by design.
- Stall FSM (registered state):
  - RUN → STALL when `hz`=1 and `flush`=0. In the hazard cycle, `stall`=1 and `out_inst`=NOP.
  - STALL → RUN unconditionally after one cycle. In the STALL-state cycle, `hz` is re-evaluated; by then `ex_inst` is the bubble, so `hz`=0.
  - A second bubble requires a new hazard; no back-to-back stall beyond one cycle arises from a single load.
- Flush:
  - `flush`=1 forces `out_inst`=NOP and `stall`=0 that cycle, regardless of `hz`.
  - Flush takes priority over stall. The FSM stays in or returns to RUN.
- `stall_cnt` increments on each clock edge where `stall`=1. It saturates at 2^CW−1 and does not wrap.
- Operand outputs are not gated on bubble; EXE ignores them for NOP.

## Timing
- Combinational from `in_inst`/`ex_inst`/`wb_*`/`flush` to `out_*` and `stall`. Zero-cycle latency; the ID/EXE register provides the stage boundary.
- Register write and FSM/counter updates occur on the rising edge of `clk`.
- Write-then-read of the same register in one cycle returns the new value (bypass), not the stale entry.
- Reset (`rst_n`=0, asynchronous):
  - All 32 registers are cleared to 0; FSM = RUN; `stall_cnt` = 0.
  - `stall` = 0; `out_inst` = NOP; `out_r1` = `out_r2` = 0. These are forced while reset is asserted.
- Reset mid-stall: the FSM returns to RUN immediately, and no bubble is carried over after release.
- Writeback and hazard in the same cycle are independent; both take effect.

## Structure
- Shared package `risc_pkg`:
  - `DW`, `IW`
  - opcode constants (`OP_LOAD`, `OP_STORE` = 6'h2B)
  - `NOP`
  - field-slice index constants
  - a `stage_state_t` enum (RUN, STALL)
- One sub-module: `regfile`, a 2-read/1-write, r0-zero register file with async reset and write-through bypass. Hazard logic, FSM and counter stay in `id_stage`.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_inst` reading r5 → `out_r1`=0, `out_inst`=0, `stall_cnt`=0. Release and read r5 → 0.
- **Write/read and bypass:**
  - Write r3=32'hDEAD_BEEF. The next cycle, reading rs1=3 → `out_r1`=32'hDEAD_BEEF.
  - Same-cycle write r4=32'h1234 while reading rs2=4 → `out_r2`=32'h1234.
- **r0 protection:** `wb_en`=1, `wb_rd`=0, `wb_data`=32'hFFFF_FFFF → reading r0 gives 0.
- **Load-use:**
  - `ex_inst` = load with rd=7; `in_inst` has rs1=7 → `stall`=1 and `out_inst`=0 for exactly one cycle, `stall_cnt` increments 0→1.
  - Next cycle, with `ex_inst`=NOP → `stall`=0, `out_inst`=`in_inst`.
- **Flush priority:** hazard present with `flush`=1 → `stall`=0, `out_inst`=0, `stall_cnt` unchanged.
- **Saturation and reset mid-stall:**
  - With `CW`=2, force 5 hazards → `stall_cnt` sticks at 3.
  - Assert `rst_n`=0 during a STALL cycle → `stall`=0 immediately, `stall_cnt`=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 5-stage RISC pipeline: widths, opcodes and
// instruction field positions.
package risc_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 32;

  localparam logic [5:0]  OP_LOAD  = 6'h23;
  localparam logic [5:0]  OP_STORE = 6'h2B;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RD_HI  = 25;
  localparam int unsigned RD_LO  = 21;
  localparam int unsigned RS1_HI = 20;
  localparam int unsigned RS1_LO = 16;
  localparam int unsigned RS2_HI = 15;
  localparam int unsigned RS2_LO = 11;

  typedef enum logic [0:0] {
    StRun,
    StStall
  } stage_state_t;

endpackage

// File: rtl/regfile.sv
// 2-read/1-write register file; entry 0 is hardwired to zero and reads see
// a same-cycle write (write-through bypass).
module regfile #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem_q [NREG];
  logic          wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = (wr_ok && (waddr == raddr1)) ? wdata : mem_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = (wr_ok && (waddr == raddr2)) ? wdata : mem_q[raddr2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: operand read with bypass, load-use hazard detection
// with one-cycle bubble insertion, and a saturating bubble counter.
module id_stage
  import risc_pkg::*;
#(
  parameter int unsigned DW   = risc_pkg::DW,
  parameter int unsigned IW   = risc_pkg::IW,
  parameter int unsigned NREG = 32,
  parameter int unsigned CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] in_inst,
  input  logic [IW-1:0] ex_inst,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] out_r1,
  output logic [DW-1:0] out_r2,
  output logic [IW-1:0] out_inst,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  logic [4:0]    rs1, rs2, ex_rd;
  logic [5:0]    ex_op;
  logic [DW-1:0] rd1, rd2;
  logic          hz, stall_raw;
  logic [CW-1:0] cnt_q, cnt_d;
  stage_state_t  state_q, state_d;
  logic          unused_ex;

  assign rs1   = in_inst[RS1_HI:RS1_LO];
  assign rs2   = in_inst[RS2_HI:RS2_LO];
  assign ex_op = ex_inst[OPC_HI:OPC_LO];
  assign ex_rd = ex_inst[RD_HI:RD_LO];
  assign unused_ex = ^{ex_inst[RS1_HI:0]};

  regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // rs2 is compared for every opcode, even those that do not read it.
  assign hz = (ex_op == OP_LOAD) && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
  assign stall_raw = hz && !flush;

  always_comb begin
    state_d = StRun;
    unique case (state_q)
      StRun:   state_d = stall_raw ? StStall : StRun;
      StStall: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_raw && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    out_r1   = '0;
    out_r2   = '0;
    out_inst = NOP;
    stall    = 1'b0;
    if (rst_n) begin
      out_r1   = rd1;
      out_r2   = rd2;
      stall    = stall_raw;
      out_inst = (flush || stall_raw) ? NOP : in_inst;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_id_stage;

  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   in_inst, ex_inst;
  logic          flush, wb_en;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [31:0]   out_r1, out_r2, out_inst;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_stage #(
    .DW   (32),
    .IW   (32),
    .NREG (32),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_inst   (in_inst),
    .ex_inst   (ex_inst),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_r1    (out_r1),
    .out_r2    (out_r2),
    .out_inst  (out_inst),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] inst;
    logic        stall;
    int          cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  int          m_cnt;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {op, rd, s1, s2, 11'h000};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && wrd == idx) return wd;
    return m_regs[idx];
  endfunction

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, "out_r1", out_r1, e.r1);
      check(nm, "out_r2", out_r2, e.r2);
      check(nm, "out_inst", out_inst, e.inst);
      check(nm, "stall", {31'h0, stall}, {31'h0, e.stall});
      check(nm, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end

  // Drives one cycle, pushes the expectation, then advances the model at the edge.
  task automatic step(input string nm, input logic rn, input logic [31:0] inst,
                      input logic [31:0] ex, input logic fl, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd);
    exp_t e;
    logic [5:0] ex_op;
    logic [4:0] ex_rd, s1, s2;
    logic hz;
    rst_n = rn; in_inst = inst; ex_inst = ex; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    if (!rn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
      e = '{r1: 32'h0, r2: 32'h0, inst: 32'h0, stall: 1'b0, cnt: 0};
    end else begin
      ex_op = ex[31:26]; ex_rd = ex[25:21]; s1 = inst[20:16]; s2 = inst[15:11];
      hz = (ex_op == 6'h23) && (ex_rd != 0) && (ex_rd == s1 || ex_rd == s2);
      e.r1    = m_read(s1, we, wrd, wd);
      e.r2    = m_read(s2, we, wrd, wd);
      e.stall = hz && !fl;
      e.inst  = (fl || e.stall) ? 32'h0 : inst;
      e.cnt   = m_cnt;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    if (rn) begin
      if (we && wrd != 0) m_regs[wrd] = wd;
      if (e.stall && m_cnt < CNTMAX) m_cnt++;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ld7, nopi;
    ld7  = mk(6'h23, 5'd7, 5'd1, 5'd2);
    nopi = 32'h0;
    rst_n = 1'b0; in_inst = '0; ex_inst = '0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0;
    @(posedge clk); #1;

    step("reset_hold", 0, mk(6'h01, 5'd1, 5'd5, 5'd5), nopi, 0, 0, 0, 0);
    step("reset_rel",  1, mk(6'h01, 5'd1, 5'd5, 5'd5), nopi, 0, 0, 0, 0);
    step("wr_r3",      1, nopi, nopi, 0, 1, 5'd3, 32'hDEAD_BEEF);
    step("rd_r3",      1, mk(6'h01, 5'd1, 5'd3, 5'd0), nopi, 0, 0, 0, 0);
    step("bypass_r4",  1, mk(6'h01, 5'd1, 5'd0, 5'd4), nopi, 0, 1, 5'd4, 32'h0000_1234);
    step("r0_wr",      1, mk(6'h01, 5'd1, 5'd0, 5'd0), nopi, 0, 1, 5'd0, 32'hFFFF_FFFF);
    step("r0_rd",      1, mk(6'h01, 5'd1, 5'd0, 5'd0), nopi, 0, 0, 0, 0);
    step("lu_hazard",  1, mk(6'h01, 5'd2, 5'd7, 5'd3), ld7, 0, 0, 0, 0);
    step("lu_release", 1, mk(6'h01, 5'd2, 5'd7, 5'd3), nopi, 0, 0, 0, 0);
    step("flush_prio", 1, mk(6'h01, 5'd2, 5'd7, 5'd3), ld7, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step("sat_hz",  1, mk(6'h01, 5'd2, 5'd4, 5'd7), ld7, 0, 0, 0, 0);
      step("sat_nop", 1, mk(6'h01, 5'd2, 5'd4, 5'd7), nopi, 0, 0, 0, 0);
    end
    step("mid_hz",     1, mk(6'h01, 5'd2, 5'd7, 5'd3), ld7, 0, 0, 0, 0);
    step("mid_reset",  0, mk(6'h01, 5'd2, 5'd7, 5'd3), ld7, 0, 0, 0, 0);
    step("post_rst",   1, mk(6'h01, 5'd2, 5'd3, 5'd4), nopi, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      logic [5:0] op, eop;
      logic [31:0] a, b;
      op  = ($urandom_range(0, 3) == 0) ? 6'h23 : 6'($urandom_range(0, 63));
      eop = ($urandom_range(0, 1) == 0) ? 6'h23 : 6'($urandom_range(0, 63));
      a = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      b = mk(eop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      a[10:0] = 11'($urandom);
      b[10:0] = 11'($urandom);
      step("random", ($urandom_range(0, 60) != 0), a, b, ($urandom_range(0, 9) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
